// File: rtl/trap_sequencer.sv
// Trap sequencer for the HarvOS S-mode core: arbitrates exceptions, interrupts and sret,
// then flushes, writes sepc/scause/stval/sstatus over one CSR port and redirects fetch.
module trap_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic [31:0] exc_pc,
    input  logic [31:0] commit_pc,
    input  logic [2:0]  irq_pending,
    input  logic [2:0]  sie_q,
    input  logic [31:0] sstatus_q,
    input  logic [31:0] csr_stvec_q,
    input  logic [31:0] csr_sepc_q,
    input  logic        sret_req,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        csr_we,
    output logic [1:0]  csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        priv,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        W_SEPC,
        W_SCAUSE,
        W_STVAL,
        W_SSTATUS,
        REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC,
        KIND_IRQ,
        KIND_SRET
    } kind_t;

    state_t      state;
    kind_t       kind;
    logic [31:0] lat_cause;
    logic [31:0] lat_tval;
    logic [31:0] lat_epc;
    logic        lat_priv;

    logic [2:0]  irq_masked;
    logic        irq_eligible;
    logic [3:0]  irq_code;
    logic [31:0] trap_sstatus;
    logic [31:0] sret_sstatus;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    // Interrupt code lives in lat_cause[3:0], which also drives the vectored offset.
    always_comb begin
        irq_masked   = irq_pending & sie_q;
        irq_eligible = (|irq_masked) && (!priv || sstatus_q[1]);
        irq_code     = irq_masked[2] ? 4'd9 : (irq_masked[0] ? 4'd1 : 4'd5);

        trap_sstatus    = sstatus_q;
        trap_sstatus[5] = sstatus_q[1];
        trap_sstatus[1] = 1'b0;
        trap_sstatus[8] = lat_priv;

        sret_sstatus    = sstatus_q;
        sret_sstatus[1] = sstatus_q[5];
        sret_sstatus[5] = 1'b1;
        sret_sstatus[8] = 1'b0;

        trap_base   = {csr_stvec_q[31:2], 2'b00};
        trap_target = trap_base;
        if (kind == KIND_IRQ && csr_stvec_q[1:0] == 2'b01) begin
            trap_target = trap_base + {26'd0, lat_cause[3:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            kind           <= KIND_EXC;
            lat_cause      <= 32'd0;
            lat_tval       <= 32'd0;
            lat_epc        <= 32'd0;
            lat_priv       <= 1'b1;
            priv           <= 1'b1;
            busy           <= 1'b0;
            flush_req      <= 1'b0;
            csr_we         <= 1'b0;
            csr_waddr      <= 2'd0;
            csr_wdata      <= 32'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            csr_we         <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        kind      <= KIND_EXC;
                        lat_cause <= {27'd0, exc_cause};
                        lat_tval  <= exc_tval;
                        lat_epc   <= exc_pc;
                    end else if (irq_eligible) begin
                        kind      <= KIND_IRQ;
                        lat_cause <= {1'b1, 27'd0, irq_code};
                        lat_tval  <= 32'd0;
                        lat_epc   <= commit_pc;
                    end else if (sret_req) begin
                        kind <= KIND_SRET;
                    end
                    if (exc_valid || irq_eligible || sret_req) begin
                        lat_priv  <= priv;
                        state     <= FLUSH;
                        busy      <= 1'b1;
                        flush_req <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        flush_req <= 1'b0;
                        csr_we    <= 1'b1;
                        if (kind == KIND_SRET) begin
                            state     <= W_SSTATUS;
                            csr_waddr <= 2'd3;
                            csr_wdata <= sret_sstatus;
                        end else begin
                            state     <= W_SEPC;
                            csr_waddr <= 2'd0;
                            csr_wdata <= lat_epc;
                        end
                    end
                end
                W_SEPC: begin
                    state     <= W_SCAUSE;
                    csr_we    <= 1'b1;
                    csr_waddr <= 2'd1;
                    csr_wdata <= lat_cause;
                end
                W_SCAUSE: begin
                    state     <= W_STVAL;
                    csr_we    <= 1'b1;
                    csr_waddr <= 2'd2;
                    csr_wdata <= lat_tval;
                end
                W_STVAL: begin
                    state     <= W_SSTATUS;
                    csr_we    <= 1'b1;
                    csr_waddr <= 2'd3;
                    csr_wdata <= trap_sstatus;
                end
                // sstatus still holds its pre-write value here, so SPP is the old privilege.
                W_SSTATUS: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    if (kind == KIND_SRET) begin
                        redirect_pc <= csr_sepc_q;
                        priv        <= sstatus_q[8];
                    end else begin
                        redirect_pc <= trap_target;
                        priv        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios followed by randomized
// requests, each checked against a transaction-level model of a whole trap episode.
module tb_trap_sequencer;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] exc_pc;
    logic [31:0] commit_pc;
    logic [2:0]  irq_pending;
    logic [2:0]  sie_q;
    logic [31:0] sstatus_q;
    logic [31:0] csr_stvec_q;
    logic [31:0] csr_sepc_q;
    logic        sret_req;
    logic        flush_req;
    logic        flush_ack;
    logic        csr_we;
    logic [1:0]  csr_waddr;
    logic [31:0] csr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        priv;
    logic        busy;

    trap_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .exc_pc         (exc_pc),
        .commit_pc      (commit_pc),
        .irq_pending    (irq_pending),
        .sie_q          (sie_q),
        .sstatus_q      (sstatus_q),
        .csr_stvec_q    (csr_stvec_q),
        .csr_sepc_q     (csr_sepc_q),
        .sret_req       (sret_req),
        .flush_req      (flush_req),
        .flush_ack      (flush_ack),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .priv           (priv),
        .busy           (busy)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          checks;
    int          fails;
    logic        model_priv;
    logic        accept;
    wr_t         exp_writes[$];
    logic [31:0] exp_pc;
    logic        exp_priv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkIdle();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_flush_req", 32'(flush_req), 32'd0);
        checkOutput("idle_csr_we", 32'(csr_we), 32'd0);
        checkOutput("idle_redirect", 32'(redirect_valid), 32'd0);
        checkOutput("idle_priv", 32'(priv), 32'(model_priv));
    endtask

    // Whole-episode reference: which request wins, the CSR writes it implies, and the redirect.
    task automatic decideRequest();
        logic [2:0]  masked;
        logic        elig;
        logic [31:0] code;
        logic [31:0] base;
        logic [31:0] trap_s;
        logic [31:0] sret_s;
        masked = irq_pending & sie_q;
        elig   = (masked != 3'b000) && (model_priv == 1'b0 || sstatus_q[1] == 1'b1);
        if (masked[2])      code = 32'd9;
        else if (masked[0]) code = 32'd1;
        else                code = 32'd5;
        base   = csr_stvec_q & ~32'd3;
        trap_s = (sstatus_q & ~32'h0000_0122) | (sstatus_q[1] ? 32'h20 : 32'h0)
                 | (model_priv ? 32'h100 : 32'h0);
        sret_s = (sstatus_q & ~32'h0000_0122) | (sstatus_q[5] ? 32'h2 : 32'h0) | 32'h20;
        exp_writes.delete();
        accept = 1'b0;
        if (exc_valid) begin
            accept = 1'b1;
            exp_writes.push_back('{2'd0, exc_pc});
            exp_writes.push_back('{2'd1, 32'(exc_cause)});
            exp_writes.push_back('{2'd2, exc_tval});
            exp_writes.push_back('{2'd3, trap_s});
            exp_pc   = base;
            exp_priv = 1'b1;
        end else if (elig) begin
            accept = 1'b1;
            exp_writes.push_back('{2'd0, commit_pc});
            exp_writes.push_back('{2'd1, 32'h8000_0000 + code});
            exp_writes.push_back('{2'd2, 32'd0});
            exp_writes.push_back('{2'd3, trap_s});
            exp_pc   = (csr_stvec_q[1:0] == 2'd1) ? base + code * 32'd4 : base;
            exp_priv = 1'b1;
        end else if (sret_req) begin
            accept = 1'b1;
            exp_writes.push_back('{2'd3, sret_s});
            exp_pc   = csr_sepc_q;
            exp_priv = sstatus_q[8];
        end
    endtask

    task automatic scrambleRequests();
        exc_valid = 1'($urandom);
        sret_req  = 1'($urandom);
        exc_cause = 5'($urandom);
        exc_pc    = $urandom;
        exc_tval  = $urandom;
        commit_pc = $urandom;
    endtask

    task automatic runEpisode(input int stall);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("flush_busy", 32'(busy), 32'd1);
            checkOutput("flush_req", 32'(flush_req), 32'd1);
            checkOutput("flush_csr_we", 32'(csr_we), 32'd0);
            checkOutput("flush_redirect", 32'(redirect_valid), 32'd0);
            scrambleRequests();
            flush_ack = (i == stall);
        end
        foreach (exp_writes[k]) begin
            @(negedge clk);
            checkOutput("wr_csr_we", 32'(csr_we), 32'd1);
            checkOutput("wr_csr_waddr", 32'(csr_waddr), 32'(exp_writes[k].addr));
            checkOutput("wr_csr_wdata", csr_wdata, exp_writes[k].data);
            checkOutput("wr_busy", 32'(busy), 32'd1);
            checkOutput("wr_flush_req", 32'(flush_req), 32'd0);
            checkOutput("wr_redirect", 32'(redirect_valid), 32'd0);
            scrambleRequests();
            flush_ack = 1'($urandom);
        end
        @(negedge clk);
        checkOutput("rd_valid", 32'(redirect_valid), 32'd1);
        checkOutput("rd_pc", redirect_pc, exp_pc);
        checkOutput("rd_priv", 32'(priv), 32'(exp_priv));
        checkOutput("rd_busy", 32'(busy), 32'd1);
        checkOutput("rd_csr_we", 32'(csr_we), 32'd0);
        model_priv = exp_priv;
        exc_valid  = 1'b0;
        sret_req   = 1'b0;
        flush_ack  = 1'b0;
    endtask

    // Called on the falling edge of an IDLE cycle with that cycle's inputs already driven.
    task automatic runCycle(input int stall);
        checkIdle();
        decideRequest();
        if (accept) runEpisode(stall);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        exc_valid   = ($urandom_range(0, 3) == 0);
        exc_cause   = 5'($urandom);
        exc_tval    = $urandom;
        exc_pc      = $urandom;
        commit_pc   = $urandom;
        irq_pending = 3'($urandom);
        sie_q       = 3'($urandom);
        sstatus_q   = $urandom;
        csr_stvec_q = $urandom;
        csr_sepc_q  = $urandom;
        sret_req    = ($urandom_range(0, 2) == 0);
        flush_ack   = 1'($urandom);
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        model_priv  = 1'b1;
        rst         = 1'b1;
        exc_valid   = 1'b0;
        exc_cause   = 5'd0;
        exc_tval    = 32'd0;
        exc_pc      = 32'd0;
        commit_pc   = 32'd0;
        irq_pending = 3'd0;
        sie_q       = 3'd0;
        sstatus_q   = 32'd0;
        csr_stvec_q = 32'd0;
        csr_sepc_q  = 32'd0;
        sret_req    = 1'b0;
        flush_ack   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_flush_req", 32'(flush_req), 32'd0);
        checkOutput("rst_csr_we", 32'(csr_we), 32'd0);
        checkOutput("rst_csr_waddr", 32'(csr_waddr), 32'd0);
        checkOutput("rst_csr_wdata", csr_wdata, 32'd0);
        checkOutput("rst_redirect", 32'(redirect_valid), 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst_priv", 32'(priv), 32'd1);
        rst = 1'b0;

        $display("[TB] illegal instruction exception");
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        csr_stvec_q = 32'h8000_0001; sstatus_q = 32'h2;
        runCycle(0);

        $display("[TB] vectored timer interrupt");
        irq_pending = 3'b010; sie_q = 3'b010; sstatus_q = 32'h2; commit_pc = 32'h200;
        runCycle(0);
        irq_pending = 3'b000;

        $display("[TB] exception beats external interrupt");
        exc_valid = 1'b1; exc_cause = 5'd13; exc_pc = 32'h300; exc_tval = 32'h44;
        irq_pending = 3'b100; sie_q = 3'b100;
        runCycle(0);
        runCycle(0);
        irq_pending = 3'b000;

        $display("[TB] masked timer interrupt, then sret to U, then interrupt taken");
        irq_pending = 3'b010; sie_q = 3'b010; sstatus_q = 32'h20; csr_sepc_q = 32'h400;
        repeat (5) runCycle(0);
        sret_req = 1'b1;
        runCycle(0);
        runCycle(0);
        irq_pending = 3'b000;

        $display("[TB] flush stalled for 10 cycles");
        exc_valid = 1'b1; exc_cause = 5'd7; exc_pc = 32'h500; exc_tval = 32'h1234;
        runCycle(10);

        $display("[TB] reset in W_SCAUSE");
        checkIdle();
        exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h600; flush_ack = 1'b1;
        @(negedge clk);
        exc_valid = 1'b0;
        checkOutput("rm_flush_req", 32'(flush_req), 32'd1);
        @(negedge clk);
        checkOutput("rm_sepc_we", 32'(csr_we), 32'd1);
        @(negedge clk);
        checkOutput("rm_scause_addr", 32'(csr_waddr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush_ack = 1'b0;
        model_priv = 1'b1;
        checkOutput("rm_busy", 32'(busy), 32'd0);
        checkOutput("rm_csr_we", 32'(csr_we), 32'd0);
        checkOutput("rm_priv", 32'(priv), 32'd1);
        checkOutput("rm_flush_req", 32'(flush_req), 32'd0);
        checkOutput("rm_csr_wdata", csr_wdata, 32'd0);
        checkOutput("rm_redirect_pc", redirect_pc, 32'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("rm_no_redirect", 32'(redirect_valid), 32'd0);
            checkOutput("rm_no_write", 32'(csr_we), 32'd0);
            @(negedge clk);
        end

        $display("[TB] randomized requests");
        for (int n = 0; n < 120; n++) begin
            applyStimulus();
            runCycle($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
